// File: rtl/sc_fir_acc.sv
// Sequences one FIR output sample as a series of 4-tap group requests to a
// stochastic-computing MAC and accumulates the returned group results.
module sc_fir_acc #(
    parameter int NBITS   = 8,
    parameter int FIRLOG  = 8,
    parameter int TIMEOUT = 300,
    localparam int ACCW   = NBITS + 2 + FIRLOG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FIRLOG-1:0] n_groups,
    output logic              mac_start,
    output logic [FIRLOG-1:0] group_idx,
    input  logic              mac_valid,
    input  logic [NBITS+1:0]  mac_in,
    output logic [ACCW-1:0]   acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [FIRLOG-1:0] group_idx_q, group_idx_d;
    logic [FIRLOG-1:0] last_q, last_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              mac_start_q, mac_start_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        group_idx_d = group_idx_q;
        last_d      = last_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d       = '0;
                    group_idx_d = '0;
                    last_d      = (n_groups == '0) ? '0 : n_groups - FIRLOG'(1);
                    err_d       = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A result arriving in the expiry cycle still counts.
                if (mac_valid) begin
                    acc_d = acc_q + ACCW'(mac_in);
                    if (group_idx_q == last_q) begin
                        state_d = OUT;
                    end else begin
                        group_idx_d = group_idx_q + FIRLOG'(1);
                        state_d     = ISSUE;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    acc_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs registered from the next state so they align with it.
    always_comb begin
        mac_start_d = (state_d == ISSUE);
        out_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            group_idx_q <= '0;
            last_q      <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            mac_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            group_idx_q <= group_idx_d;
            last_q      <= last_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            mac_start_q <= mac_start_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign mac_start = mac_start_q;
    assign group_idx = group_idx_q;
    assign acc_out   = acc_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sc_fir_acc.sv
// Directed bench for sc_fir_acc: a scripted MAC responder with hand-computed sums.
module tb_sc_fir_acc;
    localparam int NBITS   = 8;
    localparam int FIRLOG  = 8;
    localparam int TIMEOUT = 300;
    localparam int ACCW    = NBITS + 2 + FIRLOG;

    logic              clk;
    logic              rst;
    logic              start;
    logic [FIRLOG-1:0] n_groups;
    logic              mac_start;
    logic [FIRLOG-1:0] group_idx;
    logic              mac_valid;
    logic [NBITS+1:0]  mac_in;
    logic [ACCW-1:0]   acc_out;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              err;

    int n_chk = 0;
    int n_err = 0;
    logic [NBITS+1:0] mv [0:255];

    sc_fir_acc #(.NBITS(NBITS), .FIRLOG(FIRLOG), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .n_groups(n_groups),
        .mac_start(mac_start), .group_idx(group_idx), .mac_valid(mac_valid),
        .mac_in(mac_in), .acc_out(acc_out), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full sample: each group answered d cycles after its mac_start,
    // then hold cycles in OUT with out_ready low before acceptance.
    task automatic run(input int ng, input int d, input int hold);
        int groups;
        logic [31:0] sum;
        logic [31:0] held;
        groups = (ng == 0) ? 1 : ng;
        sum = 0;
        n_groups = ng[FIRLOG-1:0];
        start = 1'b1;
        step();
        start = 1'b0;
        n_groups = 8'hA5;
        chk("err_cleared", {31'd0, err}, 0);
        chk("busy_run", {31'd0, busy}, 1);
        for (int g = 0; g < groups; g++) begin
            chk("mac_start_hi", {31'd0, mac_start}, 1);
            chk("group_idx", {24'd0, group_idx}, g);
            for (int i = 0; i < d; i++) begin
                step();
                if (i == 0) chk("mac_start_pulse", {31'd0, mac_start}, 0);
            end
            mac_valid = 1'b1;
            mac_in = mv[g];
            sum += 32'(mv[g]);
            step();
            mac_valid = 1'b0;
        end
        chk("out_valid_hi", {31'd0, out_valid}, 1);
        chk("acc_out", 32'(acc_out), sum);
        held = 32'(acc_out);
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            n_groups = 8'd9;
            mac_valid = 1'b1;
            mac_in = 10'd77;
            step();
            chk("hold_valid", {31'd0, out_valid}, 1);
            chk("hold_acc", 32'(acc_out), held);
        end
        start = 1'b0;
        mac_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid_lo", {31'd0, out_valid}, 0);
        chk("busy_idle", {31'd0, busy}, 0);
        chk("acc_hold_idle", 32'(acc_out), sum);
    endtask

    initial begin
        int cycles;
        logic saw_ov;
        rst = 1'b0;
        start = 1'b0;
        n_groups = '0;
        mac_valid = 1'b0;
        mac_in = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_acc", 32'(acc_out), 0);
        chk("rst_outs", {26'd0, mac_start, out_valid, busy, err, |group_idx, 1'b0}, 0);
        repeat (2) step();
        rst = 1'b1;
        step();

        // three groups with slow MAC responses
        mv[0] = 10'd10; mv[1] = 10'd20; mv[2] = 10'd30;
        run(3, 256, 0);

        // n_groups 0 and 1 both mean a single group
        mv[0] = 10'd1023;
        run(0, 2, 0);
        run(1, 2, 0);

        // result arriving in the expiry cycle wins over timeout
        mv[0] = 10'd9;
        run(1, TIMEOUT, 0);
        chk("prec_err", {31'd0, err}, 0);

        // back-pressure with stray start/mac_valid pulses
        mv[0] = 10'd100; mv[1] = 10'd200;
        run(2, 3, 5);

        // timeout on the second group
        n_groups = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("to_ms1", {31'd0, mac_start}, 1);
        repeat (3) step();
        mac_valid = 1'b1;
        mac_in = 10'd4;
        step();
        mac_valid = 1'b0;
        chk("to_ms2", {31'd0, mac_start}, 1);
        chk("to_gidx", {24'd0, group_idx}, 1);
        cycles = 0;
        saw_ov = 1'b0;
        while (busy && cycles < 400) begin
            step();
            cycles++;
            if (out_valid) saw_ov = 1'b1;
        end
        chk("to_cycles", cycles, TIMEOUT + 1);
        chk("to_err", {31'd0, err}, 1);
        chk("to_acc", 32'(acc_out), 0);
        chk("to_no_ov", {31'd0, saw_ov}, 0);
        repeat (3) step();
        chk("to_err_sticky", {31'd0, err}, 1);
        mv[0] = 10'd3;
        run(1, 2, 0);

        // asynchronous reset in WAIT of group 1
        n_groups = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        mac_valid = 1'b1;
        mac_in = 10'd50;
        step();
        mac_valid = 1'b0;
        repeat (3) step();
        chk("pre_rst_busy", {31'd0, busy}, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_acc", 32'(acc_out), 0);
        chk("arst_outs", {26'd0, mac_start, out_valid, busy, err, |group_idx, 1'b0}, 0);
        step();
        rst = 1'b1;
        saw_ov = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid || busy || mac_start) saw_ov = 1'b1;
        end
        chk("post_rst_quiet", {31'd0, saw_ov}, 0);
        mv[0] = 10'd7;
        run(1, 2, 0);

        // full-scale sample without wrap
        for (int g = 0; g < 256; g++) mv[g] = 10'd1023;
        run(255, 1, 0);
        chk("max_acc", 32'(acc_out), 260865);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
